// File: rtl/riscv_32i_config_pkg.sv
// Core-wide sizing constants for the riscv_32i memory system.
package riscv_32i_config_pkg;
  localparam int DATA_MEM_DEPTH = 256;
endpackage

// File: rtl/riscv_32i_control_pkg.sv
// Load/store control encodings: per-byte write-lane selects.
package riscv_32i_control_pkg;
  typedef logic [3:0] wr_sel_t;

  localparam wr_sel_t WR_NONE  = 4'b0000;
  localparam wr_sel_t WR_BYTE0 = 4'b0001;
  localparam wr_sel_t WR_HALF0 = 4'b0011;
  localparam wr_sel_t WR_WORD  = 4'b1111;
endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// Basic datapath types shared by the riscv_32i core.
package riscv_32i_defs_pkg;
  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;
endpackage

// File: rtl/data_mem_intf.sv
// Signal bundle between the load/store path and data_mem; carries no logic.
interface data_mem_intf (
  input logic clk
);
  import riscv_32i_defs_pkg::*;
  import riscv_32i_control_pkg::*;

  wr_sel_t wr_sel;
  word_t   addr;
  word_t   wr_data;
  word_t   rd_data;
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory: combinational read, byte-lane synchronous write.
// Optional DATA_MEM_ADDR_CHECK_EN: out-of-range accesses read 0 / drop writes and raise $error.
module data_mem
  import riscv_32i_config_pkg::*;
  import riscv_32i_defs_pkg::*;
  import riscv_32i_control_pkg::*;
#(
  parameter int DEPTH = DATA_MEM_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  wr_sel_t wr_sel,
  input  word_t   addr,
  input  word_t   wr_data,
  output word_t   rd_data
);
  localparam int IDX_W = $clog2(DEPTH);

  word_t            mem_q [DEPTH];
  word_t            word_d;
  logic [IDX_W-1:0] idx;
  logic             wr_en;

  assign idx = addr[IDX_W+1:2];

`ifdef DATA_MEM_ADDR_CHECK_EN
  logic in_range;
  assign in_range = (addr[31:IDX_W+2] == '0);
  assign rd_data  = in_range ? mem_q[idx] : '0;
  assign wr_en    = in_range && (wr_sel != WR_NONE);

  always @(posedge clk) begin
    if (!rst) begin
      if (!in_range)
        $error("data_mem: out-of-range access addr=%h wr_sel=%b", addr, wr_sel);
      if ((wr_sel != WR_NONE) && (addr[1:0] != 2'b00))
        $error("data_mem: misaligned write addr=%h wr_sel=%b", addr, wr_sel);
    end
  end
`else
  // Low offset bits and high bits are dropped: word-aligned, wraps modulo DEPTH*4.
  logic unused_addr;
  assign unused_addr = ^{addr[1:0], addr[31:IDX_W+2]};
  assign rd_data     = mem_q[idx];
  assign wr_en       = (wr_sel != WR_NONE);
`endif

  always_comb begin
    word_d = mem_q[idx];
    for (int b = 0; b < 4; b++)
      if (wr_sel[b]) word_d[8*b +: 8] = wr_data[8*b +: 8];
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= word_d;
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// Directed + short randomized bench for data_mem, driven through data_mem_intf.
module tb_data_mem;
  import riscv_32i_defs_pkg::*;
  import riscv_32i_control_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  data_mem_intf mif (.clk(clk));

  data_mem dut (
    .clk    (clk),
    .rst    (rst),
    .wr_sel (mif.wr_sel),
    .addr   (mif.addr),
    .wr_data(mif.wr_data),
    .rd_data(mif.rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input wr_sel_t s, input word_t a, input word_t d);
    mif.wr_sel  = s;
    mif.addr    = a;
    mif.wr_data = d;
  endtask

  word_t model [256];

  initial begin
    word_t   exp_w;
    wr_sel_t rs;
    word_t   ra;
    word_t   rd;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(WR_NONE, 32'h0, 32'h0);
    step();
    rst = 1'b0;

    drive(WR_NONE, 32'h0, 32'h0);   #1; chk("rst_rd_0",   mif.rd_data, 32'h0);
    drive(WR_NONE, 32'h4, 32'h0);   #1; chk("rst_rd_4",   mif.rd_data, 32'h0);
    drive(WR_NONE, 32'h3FC, 32'h0); #1; chk("rst_rd_3fc", mif.rd_data, 32'h0);

    // no write-through before the edge
    drive(WR_WORD, 32'h10, 32'hDEADBEEF); #1;
    chk("wr_pre_edge", mif.rd_data, 32'h0);
    step();
    drive(WR_NONE, 32'h10, 32'h0); #1;
    chk("wr_word", mif.rd_data, 32'hDEADBEEF);

    drive(WR_WORD, 32'h20, 32'h11223344); step();
    drive(4'b0100, 32'h20, 32'hAABBCCDD); step();
    drive(WR_NONE, 32'h20, 32'h0); #1;
    chk("lane2_merge", mif.rd_data, 32'h11BB3344);
    drive(WR_HALF0, 32'h20, 32'h99887766); step();
    drive(WR_NONE, 32'h20, 32'h0); #1;
    chk("half0_merge", mif.rd_data, 32'h11BB7766);
    drive(WR_BYTE0, 32'h20, 32'h000000EE); step();
    drive(WR_NONE, 32'h20, 32'h0); #1;
    chk("byte0_merge", mif.rd_data, 32'h11BB77EE);

    drive(WR_WORD, 32'h8, 32'hCAFEF00D); step();
    drive(WR_NONE, 32'hB, 32'h0); #1;
    chk("misalign_rd", mif.rd_data, 32'hCAFEF00D);
    drive(WR_NONE, 32'h408, 32'h0); #1;
`ifdef DATA_MEM_ADDR_CHECK_EN
    chk("oor_rd", mif.rd_data, 32'h0);
`else
    chk("wrap_rd", mif.rd_data, 32'hCAFEF00D);
`endif
    drive(WR_NONE, 32'h10, 32'h0); #1;
    chk("neighbour_keep", mif.rd_data, 32'hDEADBEEF);

    drive(WR_WORD, 32'h0, 32'h55AA55AA); step();
    drive(WR_NONE, 32'h0, 32'h0); #1;
    chk("pre_rst_word", mif.rd_data, 32'h55AA55AA);
    rst = 1'b1;
    drive(WR_WORD, 32'h0, 32'h12345678); step();
    rst = 1'b0;
    drive(WR_NONE, 32'h0, 32'h0); #1;
    chk("rst_beats_wr", mif.rd_data, 32'h0);
    drive(WR_NONE, 32'h10, 32'h0); #1;
    chk("rst_clears_10", mif.rd_data, 32'h0);

    for (int i = 0; i < 256; i++) model[i] = '0;
    for (int n = 0; n < 24; n++) begin
      rs = wr_sel_t'($urandom_range(0, 15));
      ra = word_t'($urandom_range(0, 15)) << 2;
      rd = $urandom;
      drive(rs, ra, rd);
      #3;
      chk("rand_rd", mif.rd_data, model[ra[9:2]]);
      @(posedge clk);
      exp_w = model[ra[9:2]];
      for (int b = 0; b < 4; b++)
        if (rs[b]) exp_w[8*b +: 8] = rd[8*b +: 8];
      model[ra[9:2]] = exp_w;
      #1;
    end
    drive(WR_NONE, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      mif.addr = word_t'(i) << 2;
      #1;
      chk("rand_final", mif.rd_data, model[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory for the riscv_32i core, sitting behind the load/store path.
- Reads are combinational from a byte address.
- Writes are synchronous on rising clk, gated per byte lane by wr_sel.
- Bench connects through the data_mem_intf interface, which bundles wr_sel, addr, wr_data and rd_data and takes clk as its port.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_sel  input  4  byte-lane write enable; bit i writes wr_data[8i+7:8i]; 4'b0000 = no write.
- addr  input  32  byte address.
- wr_data  input  32  write data, lane-aligned (not shifted by addr[1:0]).
- rd_data  output  32  read data of the word at addr.

Behaviour:
- Storage: DEPTH x 32-bit array, little-endian byte lanes.
- Word index = addr[IDX_W+1:2].
  - addr[1:0] ignored: accesses are word-aligned.
  - addr[31:IDX_W+2] ignored: addresses wrap modulo DEPTH*4.
- Read: rd_data is combinational from the current array contents at the index.
  - Valid within the same cycle addr changes; no read latency.
- Write: on rising clk with rst=0, each byte lane i with wr_sel[i]=1 takes wr_data byte i.
  - Lanes with wr_sel[i]=0 hold their value.
- Read-during-write, same address:
  - Before the edge, rd_data shows the old word (no write-through).
  - After the edge, rd_data shows the merged word.
- Reset: on rising clk with rst=1, every word is cleared to 32'h0000_0000.
  - Reset has priority over a simultaneous write; that write is dropped.
  - rd_data therefore reads 0 at every address after reset.
- Power-up: contents undefined until the first reset cycle.
  - The bench issues reset before checking reads.
- Reset mid-operation: takes effect at the next rising edge; no partial writes survive.
- No handshake: the memory is always ready; one access per cycle.

Optional Feature:
- Macro: DATA_MEM_ADDR_CHECK_EN.
- Defined:
  - Any addr with addr >= DEPTH*4 is out of range.
  - Out-of-range reads return 32'h0000_0000.
  - Out-of-range writes are dropped.
  - A simulation $error fires for any out-of-range access with wr_sel != 0 or a read.
  - A misaligned access (addr[1:0] != 0) with wr_sel != 0 also raises $error.
- Undefined: no checks; the address wraps as described in Behaviour.

Decomposition:
- riscv_32i_config_pkg: DATA_MEM_DEPTH constant (default for DEPTH).
- riscv_32i_defs_pkg: word_t (logic [31:0]) and byte_t (logic [7:0]).
- riscv_32i_control_pkg: wr_sel_t typedef (logic [3:0]) plus constants:
  - WR_NONE = 4'b0000
  - WR_BYTE0 = 4'b0001
  - WR_HALF0 = 4'b0011
  - WR_WORD = 4'b1111
- data_mem_intf: interface with clk input and the four data signals. It has no logic.
- No sub-module required. The array plus lane-merge logic sits inside data_mem.

Test Plan:
- Reset then read: rst=1 for one edge; read addr 0x0, 0x4, 0x3FC -> rd_data 0x00000000.
- Full-word write then read: wr_sel=4'hF, addr=0x10, wr_data=0xDEADBEEF, clock once; then wr_sel=0, addr=0x10 -> rd_data 0xDEADBEEF. Before that edge, the same addr reads 0x00000000.
- Byte-lane merge: word 0x20 = 0x11223344; then wr_sel=4'b0100, wr_data=0xAABBCCDD -> word reads 0x11BB3344.
- Alignment and wrap:
  - Write 0xCAFEF00D at 0x8; read addr 0xB -> 0xCAFEF00D.
  - With DEPTH=256, read addr 0x408 -> 0xCAFEF00D (wrap, macro undefined).
  - With DATA_MEM_ADDR_CHECK_EN defined, addr 0x408 -> 0x00000000 and $error.
- Reset beats write: rst=1 with wr_sel=4'hF, addr=0x0, wr_data=0x12345678 on the same edge -> addr 0x0 reads 0x00000000.
- Random regression: at least 10 cycles of randomized wr_sel/addr/wr_data.
  - rd_data is sampled 3 time units after drive, before the edge, and compared against a word-array reference model.
  - The model is updated after each edge.
  - Zero mismatches required.
